// File: rtl/burst_ram_pkg.sv
// Shared command encodings and FSM state type for the burst RAM arbiter.
package burst_ram_pkg;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   localparam logic OWNER_P0 = 1'b0;
   localparam logic OWNER_P1 = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      READ,
      WRITE,
      DRAIN
   } state_t;

endpackage

// File: rtl/burst_ram_arbiter.sv
// Two-port (icache p0 / dcache p1) arbiter in front of a single burst RAM.
// Define ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed p0 priority.
module burst_ram_arbiter
   import burst_ram_pkg::*;
#(
   parameter int ADDRESS_BITWIDTH = 8,
   parameter int DATA_BITWIDTH    = 64,
   parameter int BURST_COUNT      = 4
) (
   input  logic                          clk,
   input  logic                          rst,

   input  logic                          p0_cmd,
   input  logic                          p0_cmd_en,
   input  logic [ADDRESS_BITWIDTH-1:0]   p0_addr,
   input  logic [DATA_BITWIDTH-1:0]      p0_wr_data,
   input  logic [DATA_BITWIDTH/8-1:0]    p0_data_mask,
   output logic                          p0_accept,
   output logic [DATA_BITWIDTH-1:0]      p0_rd_data,
   output logic                          p0_rd_data_valid,
   output logic                          p0_busy,

   input  logic                          p1_cmd,
   input  logic                          p1_cmd_en,
   input  logic [ADDRESS_BITWIDTH-1:0]   p1_addr,
   input  logic [DATA_BITWIDTH-1:0]      p1_wr_data,
   input  logic [DATA_BITWIDTH/8-1:0]    p1_data_mask,
   output logic                          p1_accept,
   output logic [DATA_BITWIDTH-1:0]      p1_rd_data,
   output logic                          p1_rd_data_valid,
   output logic                          p1_busy,

   output logic                          br_cmd,
   output logic                          br_cmd_en,
   output logic [ADDRESS_BITWIDTH-1:0]   br_addr,
   output logic [DATA_BITWIDTH-1:0]      br_wr_data,
   output logic [DATA_BITWIDTH/8-1:0]    br_data_mask,
   input  logic [DATA_BITWIDTH-1:0]      br_rd_data,
   input  logic                          br_rd_data_valid,
   input  logic                          br_busy
);

   localparam int CW = (BURST_COUNT > 2) ? $clog2(BURST_COUNT) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_COUNT - 1);

   state_t                        state, state_nxt;
   logic [CW-1:0]                 beat, beat_nxt;
   logic                          owner, owner_nxt;
   logic                          own_cmd, own_cmd_nxt;
   logic [ADDRESS_BITWIDTH-1:0]   own_addr, own_addr_nxt;

   logic                          grant;
   logic                          pick_p1;
   logic                          acc0, acc1;

   assign grant = (state == IDLE) & (p0_cmd_en | p1_cmd_en) & ~br_busy;

`ifdef ARBITER_ROUND_ROBIN_EN
   logic last_grant;  // port granted most recently; the other one wins a tie

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       last_grant <= OWNER_P0;
      else if (grant) last_grant <= pick_p1;
   end

   always_comb pick_p1 = (p0_cmd_en & p1_cmd_en) ? ~last_grant : p1_cmd_en;
`else
   always_comb pick_p1 = p1_cmd_en & ~p0_cmd_en;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         beat     <= '0;
         owner    <= OWNER_P0;
         own_cmd  <= CMD_READ;
         own_addr <= '0;
      end else begin
         state    <= state_nxt;
         beat     <= beat_nxt;
         owner    <= owner_nxt;
         own_cmd  <= own_cmd_nxt;
         own_addr <= own_addr_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      beat_nxt         = beat;
      owner_nxt        = owner;
      own_cmd_nxt      = own_cmd;
      own_addr_nxt     = own_addr;
      acc0             = 1'b0;
      acc1             = 1'b0;
      br_cmd_en        = 1'b0;
      br_cmd           = 1'b0;
      br_addr          = '0;
      br_wr_data       = '0;
      br_data_mask     = '0;
      p0_rd_data       = '0;
      p1_rd_data       = '0;
      p0_rd_data_valid = 1'b0;
      p1_rd_data_valid = 1'b0;

      case (state)
         IDLE: begin
            if (grant) begin
               acc0         = ~pick_p1;
               acc1         = pick_p1;
               owner_nxt    = pick_p1;
               own_cmd_nxt  = pick_p1 ? p1_cmd  : p0_cmd;
               own_addr_nxt = pick_p1 ? p1_addr : p0_addr;
               beat_nxt     = '0;
               state_nxt    = ISSUE;
            end
         end
         ISSUE: begin
            br_cmd_en = 1'b1;
            br_cmd    = own_cmd;
            br_addr   = own_addr;
            if (own_cmd == CMD_WRITE) begin
               // beat 0 rides along with the command
               br_wr_data   = owner ? p1_wr_data   : p0_wr_data;
               br_data_mask = owner ? p1_data_mask : p0_data_mask;
               beat_nxt     = CW'(1);
               state_nxt    = WRITE;
            end else begin
               state_nxt = READ;
            end
         end
         READ: begin
            p0_rd_data = br_rd_data;
            p1_rd_data = br_rd_data;
            if (br_rd_data_valid) begin
               p0_rd_data_valid = ~owner;
               p1_rd_data_valid = owner;
               beat_nxt         = beat + 1'b1;
               if (beat == LAST_BEAT) state_nxt = IDLE;
            end
         end
         WRITE: begin
            br_wr_data   = owner ? p1_wr_data   : p0_wr_data;
            br_data_mask = owner ? p1_data_mask : p0_data_mask;
            beat_nxt     = beat + 1'b1;
            if (beat == LAST_BEAT) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!br_busy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // accept is purely combinational in IDLE, so mask it while reset is held
   assign p0_accept = acc0 & rst;
   assign p1_accept = acc1 & rst;

   assign p0_busy = (state != IDLE) | br_busy;
   assign p1_busy = (state != IDLE) | br_busy;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Scoreboard bench for burst_ram_arbiter with a behavioural burst RAM.
module tb_burst_ram_arbiter;
   import burst_ram_pkg::*;

   localparam int AW = 8;
   localparam int DW = 64;
   localparam int BC = 4;
   localparam int MW = DW / 8;
   localparam int DEPTH = (1 << AW) * BC;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]    cmd;
   logic [1:0]    cmd_en;
   logic [AW-1:0] addr    [2];
   logic [DW-1:0] wr_data [2];
   logic [MW-1:0] mask    [2];

   logic          p0_accept, p1_accept, p0_rd_data_valid, p1_rd_data_valid, p0_busy, p1_busy;
   logic [DW-1:0] p0_rd_data, p1_rd_data;
   logic          br_cmd, br_cmd_en, br_rd_data_valid, br_busy;
   logic [AW-1:0] br_addr;
   logic [DW-1:0] br_wr_data, br_rd_data;
   logic [MW-1:0] br_data_mask;

   burst_ram_arbiter dut (
      .clk(clk), .rst(rst),
      .p0_cmd(cmd[0]), .p0_cmd_en(cmd_en[0]), .p0_addr(addr[0]), .p0_wr_data(wr_data[0]),
      .p0_data_mask(mask[0]), .p0_accept(p0_accept), .p0_rd_data(p0_rd_data),
      .p0_rd_data_valid(p0_rd_data_valid), .p0_busy(p0_busy),
      .p1_cmd(cmd[1]), .p1_cmd_en(cmd_en[1]), .p1_addr(addr[1]), .p1_wr_data(wr_data[1]),
      .p1_data_mask(mask[1]), .p1_accept(p1_accept), .p1_rd_data(p1_rd_data),
      .p1_rd_data_valid(p1_rd_data_valid), .p1_busy(p1_busy),
      .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
      .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
      .br_busy(br_busy)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event/timeout expected none", name);
   endtask

   function automatic logic [DW-1:0] init_word(input int i);
      return {32'h0F1E2D3C ^ 32'(i), 32'hB7C6A980 + 32'(i) * 32'h00010001};
   endfunction

   function automatic int idx(input logic [AW-1:0] a, input int k);
      return int'(a) * BC + k;
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                           input logic [MW-1:0] m);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < MW; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   // behavioural RAM: contents survive reset, control state does not
   logic [DW-1:0] ram    [DEPTH];
   logic          ram_v  [DEPTH];
   logic          ram_busy;
   logic          force_busy = 1'b0;
   logic          rd_act, wr_act;
   int            rd_wait, rd_beat, wr_beat, drain;
   logic [AW-1:0] ram_addr;
   assign br_busy = ram_busy | force_busy;

   function automatic logic [DW-1:0] ram_rd(input int i);
      return ram_v[i] ? ram[i] : init_word(i);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_busy <= 1'b0; rd_act <= 1'b0; wr_act <= 1'b0;
         rd_wait <= 0; rd_beat <= 0; wr_beat <= 0; drain <= 0;
         ram_addr <= '0; br_rd_data <= '0; br_rd_data_valid <= 1'b0;
      end else begin
         br_rd_data_valid <= 1'b0;
         if (br_cmd_en) begin
            ram_busy <= 1'b1;
            ram_addr <= br_addr;
            if (br_cmd == CMD_WRITE) begin
               wr_act <= 1'b1; wr_beat <= 1;
               ram[idx(br_addr, 0)]   <= merge(ram_rd(idx(br_addr, 0)), br_wr_data, br_data_mask);
               ram_v[idx(br_addr, 0)] <= 1'b1;
            end else begin
               rd_act <= 1'b1; rd_wait <= 2; rd_beat <= 0;
            end
         end else if (wr_act) begin
            ram[idx(ram_addr, wr_beat)]   <= merge(ram_rd(idx(ram_addr, wr_beat)), br_wr_data, br_data_mask);
            ram_v[idx(ram_addr, wr_beat)] <= 1'b1;
            wr_beat <= wr_beat + 1;
            if (wr_beat == BC - 1) begin wr_act <= 1'b0; drain <= 3; end
         end else if (drain > 0) begin
            drain <= drain - 1;
            if (drain == 1) ram_busy <= 1'b0;
         end else if (rd_act) begin
            if (rd_wait > 0) rd_wait <= rd_wait - 1;
            else begin
               br_rd_data       <= ram_rd(idx(ram_addr, rd_beat));
               br_rd_data_valid <= 1'b1;
               rd_beat          <= rd_beat + 1;
               if (rd_beat == BC - 1) begin rd_act <= 1'b0; ram_busy <= 1'b0; end
            end
         end
      end
   end

   // reference memory and scoreboard queues
   logic [DW-1:0]   ref_w [DEPTH];
   logic            ref_v [DEPTH];
   logic [DW-1:0]   exp_rd0[$], exp_rd1[$];
   logic            exp_grant[$];
   logic [AW:0]     exp_cmd[$];
   logic [MW+DW-1:0] exp_wd[$];
   int              rd_cnt0 = 0;

   function automatic logic [DW-1:0] ref_rd(input int i);
      return ref_v[i] ? ref_w[i] : init_word(i);
   endfunction

   function automatic logic acc(input int p);
      return (p == 0) ? p0_accept : p1_accept;
   endfunction

   // monitor: compares every DUT-side event against the queues
   initial begin
      logic pacc, pbusy;
      int   wb;
      logic [DW-1:0] e;
      pacc = 1'b0; pbusy = 1'b0; wb = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin pacc = 1'b0; wb = 0; continue; end
         if (p0_accept || p1_accept) begin
            check("grant_onehot", 128'(p0_accept & p1_accept), 128'(0));
            if (exp_grant.size() == 0) fail("grant_unexpected");
            else check("grant_port", 128'(p1_accept), 128'(exp_grant.pop_front()));
         end
         if (br_cmd_en) begin
            check("cmd_en_after_free_accept", 128'({pacc, pbusy}), 128'(2'b10));
            if (exp_cmd.size() == 0) fail("br_cmd_unexpected");
            else check("br_cmd_addr", 128'({br_cmd, br_addr}), 128'(exp_cmd.pop_front()));
            if (br_cmd == CMD_WRITE) wb = BC;
         end
         if (wb > 0) begin
            if (exp_wd.size() == 0) fail("br_wr_unexpected");
            else check("br_wr_data_mask", 128'({br_data_mask, br_wr_data}), 128'(exp_wd.pop_front()));
            wb--;
         end
         pacc  = p0_accept | p1_accept;
         pbusy = br_busy;
         if (p0_rd_data_valid) begin
            rd_cnt0++;
            if (exp_rd0.size() == 0) fail("p0_rd_unexpected");
            else begin
               e = exp_rd0.pop_front();
               check("p0_rd_data", 128'(p0_rd_data), 128'(e));
               check("p1_rd_data_shared", 128'(p1_rd_data), 128'(e));
            end
         end
         if (p1_rd_data_valid) begin
            if (exp_rd1.size() == 0) fail("p1_rd_unexpected");
            else begin
               e = exp_rd1.pop_front();
               check("p1_rd_data", 128'(p1_rd_data), 128'(e));
            end
         end
      end
   end

   task automatic sync();
      @(posedge clk); #1;
   endtask

   // one requester transaction; returns cycles to accept (1 = same cycle)
   task automatic req(input int p, input logic c, input logic [AW-1:0] a,
                      input logic [DW-1:0] wstep, input logic [MW-1:0] m, output int lat);
      int n;
      n = 0;
      cmd[p] = c; addr[p] = a; cmd_en[p] = 1'b1;
      for (int k = 0; k < BC; k++) begin
         if (c == CMD_READ) begin
            if (p == 0) exp_rd0.push_back(ref_rd(idx(a, k)));
            else        exp_rd1.push_back(ref_rd(idx(a, k)));
         end else begin
            ref_w[idx(a, k)] = merge(ref_rd(idx(a, k)), wstep * (k + 1), m);
            ref_v[idx(a, k)] = 1'b1;
         end
      end
      do begin @(negedge clk); n++; end while (!acc(p) && n < 300);
      lat = n;
      if (!acc(p)) begin
         fail("accept_timeout");
         cmd_en[p] = 1'b0;
         return;
      end
      exp_cmd.push_back({c, a});
      if (c == CMD_WRITE) for (int k = 0; k < BC; k++) exp_wd.push_back({m, wstep * (k + 1)});
      @(posedge clk); #1;
      cmd_en[p] = 1'b0;
      if (c == CMD_WRITE) begin
         for (int k = 0; k < BC; k++) begin
            wr_data[p] = wstep * (k + 1); mask[p] = m;
            @(posedge clk); #1;
         end
         wr_data[p] = '0; mask[p] = '0;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin @(negedge clk); n++; end
      while ((exp_rd0.size() != 0 || exp_rd1.size() != 0 || exp_cmd.size() != 0 ||
              exp_wd.size() != 0 || exp_grant.size() != 0 || p0_busy) && n < 500);
      if (n >= 500) fail("drain_timeout");
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, lat2, base, n;
      for (int i = 0; i < DEPTH; i++) ref_v[i] = 1'b0;
      cmd = 2'b11; cmd_en = 2'b11;
      for (int p = 0; p < 2; p++) begin addr[p] = 8'hA5; wr_data[p] = '1; mask[p] = '1; end

      // reset: requests pending, everything quiet, busy follows br_busy
      force_busy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_accept", 128'({p0_accept, p1_accept}), 128'(0));
      check("rst_br_cmd", 128'({br_cmd_en, br_cmd, br_addr}), 128'(0));
      check("rst_br_wr", 128'({br_data_mask, br_wr_data}), 128'(0));
      check("rst_rd_valid", 128'({p0_rd_data_valid, p1_rd_data_valid}), 128'(0));
      check("rst_rd_data", 128'({p0_rd_data, p1_rd_data}), 128'(0));
      check("rst_busy_hi", 128'({p0_busy, p1_busy}), 128'(2'b11));
      force_busy = 1'b0;
      #1;
      check("rst_busy_lo", 128'({p0_busy, p1_busy}), 128'(0));
      cmd = 2'b00; cmd_en = 2'b00;
      for (int p = 0; p < 2; p++) begin addr[p] = '0; wr_data[p] = '0; mask[p] = '0; end
      @(negedge clk);
      rst = 1'b1;

      // single p0 read, free RAM
      sync();
      exp_grant.push_back(1'b0);
      req(0, CMD_READ, 8'h00, '0, '0, lat);
      check("p0_accept_latency", 128'(lat), 128'(1));
      wait_idle();

      // simultaneous reads
      sync();
`ifdef ARBITER_ROUND_ROBIN_EN
      exp_grant.push_back(1'b1); exp_grant.push_back(1'b0);
`else
      exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
`endif
      fork
         req(0, CMD_READ, 8'h08, '0, '0, lat);
         req(1, CMD_READ, 8'h10, '0, '0, lat2);
      join
      wait_idle();

      // p1 write burst, then p0 reads it back
      sync();
      exp_grant.push_back(1'b1);
      req(1, CMD_WRITE, 8'h20, 64'h11, 8'hFF, lat);
      wait_idle();
      sync();
      exp_grant.push_back(1'b0);
      req(0, CMD_READ, 8'h20, '0, '0, lat);
      wait_idle();

      // RAM busy holds off the accept
      sync();
      force_busy = 1'b1;
      exp_grant.push_back(1'b0);
      fork
         req(0, CMD_READ, 8'h05, '0, '0, lat);
         begin
            repeat (5) begin
               @(negedge clk);
               check("busy_no_accept", 128'(p0_accept), 128'(0));
               check("busy_flag", 128'(p0_busy), 128'(1));
            end
            @(posedge clk); #1;
            force_busy = 1'b0;
         end
      join
      check("busy_accept_late", 128'(lat > 5), 128'(1));
      wait_idle();

      // p0 back-to-back with p1 waiting
      sync();
`ifdef ARBITER_ROUND_ROBIN_EN
      exp_grant.push_back(1'b0); exp_grant.push_back(1'b1); exp_grant.push_back(1'b0);
`else
      exp_grant.push_back(1'b0); exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
`endif
      fork
         begin
            req(0, CMD_READ, 8'h01, '0, '0, lat);
            req(0, CMD_READ, 8'h02, '0, '0, lat);
         end
         begin
            sync(); sync();
            req(1, CMD_READ, 8'h03, '0, '0, lat2);
         end
      join
      wait_idle();

      // reset in the middle of a read burst
      sync();
      exp_grant.push_back(1'b0);
      base = rd_cnt0;
      req(0, CMD_READ, 8'h30, '0, '0, lat);
      n = 0;
      while (rd_cnt0 < base + 2 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) fail("mid_burst_timeout");
      #2;
      rst = 1'b0;
      #1;
      check("midrst_outputs", 128'({p0_accept, p1_accept, p0_rd_data_valid, p1_rd_data_valid,
                                    br_cmd_en, br_cmd, br_addr}), 128'(0));
      check("midrst_data", 128'({p0_rd_data, br_wr_data}), 128'(0));
      check("midrst_busy", 128'({p0_busy, p1_busy}), 128'(0));
      exp_rd0.delete();
      cmd_en[1] = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("midrst_quiet", 128'({p0_rd_data_valid, p1_accept, br_cmd_en}), 128'(0));
      end
      cmd_en[1] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (8) @(negedge clk);
      check("post_rst_no_beats", 128'(rd_cnt0), 128'(base + 2 + (rd_cnt0 - base - 2 > 0 ? 1 : 0)));
      sync();
      exp_grant.push_back(1'b0);
      req(0, CMD_READ, 8'h31, '0, '0, lat);
      check("post_rst_accept_latency", 128'(lat), 128'(1));
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/burst_ram_arbiter.md
BURST_RAM_ARBITER -- requirements
Module: burst_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_BITWIDTH, default 8, RAM burst address width.
REQ-002 SHALL have parameter DATA_BITWIDTH, default 64, bits per burst beat.
REQ-003 SHALL have parameter BURST_COUNT, default 4, beats per burst (power of 2, >=2).
REQ-004 SHALL have ports: clk in 1, the single clock; rst in 1, reset, asynchronous and active-low.
REQ-005 SHALL have, per requester X in {p0,p1} (p0 = instruction cache, p1 = data cache): X_cmd in 1, 0 read / 1 write; X_cmd_en in 1, level request; X_addr in ADDRESS_BITWIDTH; X_wr_data in DATA_BITWIDTH; X_data_mask in DATA_BITWIDTH/8.
REQ-006 SHALL have, per requester X: X_accept out 1, one-cycle grant pulse; X_rd_data out DATA_BITWIDTH; X_rd_data_valid out 1; X_busy out 1.
REQ-007 SHALL have RAM side ports br_cmd out 1, br_cmd_en out 1, br_addr out ADDRESS_BITWIDTH, br_wr_data out DATA_BITWIDTH, br_data_mask out DATA_BITWIDTH/8, br_rd_data in DATA_BITWIDTH, br_rd_data_valid in 1, br_busy in 1.

Function
REQ-008 SHALL implement FSM IDLE, ISSUE, READ, WRITE, DRAIN.
REQ-009 IDLE: if any X_cmd_en and !br_busy, SHALL pulse X_accept for the winner, latch its cmd/addr as owner, go ISSUE next cycle; else stay IDLE.
REQ-010 ISSUE: SHALL drive br_cmd_en=1 for exactly one cycle with latched cmd/addr; beat 0 of a write (owner X_wr_data/X_data_mask) SHALL be forwarded combinationally in this cycle.
REQ-011 Requester SHALL hold cmd/addr/cmd_en until X_accept; on write, SHALL present beat k on the k-th cycle after X_accept (k=0..BURST_COUNT-1).
REQ-012 ISSUE->READ for read; ISSUE->WRITE for write.
REQ-013 READ: SHALL forward br_rd_data to both X_rd_data and assert X_rd_data_valid only for owner; SHALL count valid beats; after beat BURST_COUNT-1 go IDLE.
REQ-014 WRITE: SHALL forward beats 1..BURST_COUNT-1 from owner to br_wr_data/br_data_mask, one per cycle; then DRAIN.
REQ-015 DRAIN: SHALL wait until br_busy=0, then IDLE.
REQ-016 X_busy SHALL be 1 whenever state!=IDLE or br_busy=1; owner and non-owner alike.
REQ-017 Beat counter SHALL be log2(BURST_COUNT) bits, wrap to 0 on burst end.
REQ-018 Accept latency: request with free RAM in IDLE SHALL be accepted same cycle; br_cmd_en follows next cycle.
REQ-019 br_rd_data_valid outside READ SHALL be ignored (no X_rd_data_valid).
REQ-020 br_cmd_en SHALL never assert while br_busy=1 at the time of the accept decision.
REQ-021 Simultaneous requests SHALL be resolved per REQ-025.

Reset
REQ-022 rst=0 SHALL asynchronously force IDLE, counter 0, owner p0, round-robin pointer p0.
REQ-023 During reset all outputs SHALL be 0 (X_accept, X_rd_data_valid, br_cmd_en, br_cmd, br_addr, br_wr_data, br_data_mask, X_rd_data) except X_busy, which SHALL follow br_busy.
REQ-024 Reset mid-burst SHALL abandon the burst; no further beats forwarded; RAM assumed reset with the same rst.

Configuration
REQ-025 With ARBITER_ROUND_ROBIN_EN defined, on simultaneous requests the port not granted last SHALL win, pointer updated on each accept; without it, p0 SHALL always win.

Structure
REQ-026 Package burst_ram_pkg SHALL hold CMD_READ=0, CMD_WRITE=1 and the FSM state enum.
REQ-027 No sub-module; beat counter inline.

Verification
REQ-028 p0 read addr 0x00, RAM idle -> p0_accept same cycle, br_cmd_en next cycle, 4 p0_rd_data_valid beats, first beat's low word 0xB7C6A980, p1_rd_data_valid stays 0.
REQ-029 p0 read 0x08 and p1 read 0x10 same cycle -> without macro p0 then p1; with macro after prior p0 grant, p1 first.
REQ-030 p1 write 0x20, beats 0x11..0x44, mask 0xFF -> br_cmd_en once, br_wr_data sequence 0x11,0x22,0x33,0x44 on 4 consecutive cycles, DRAIN until br_busy=0; readback by p0 returns same.
REQ-031 p0 request while br_busy=1 -> no accept until br_busy=0, then accept.
REQ-032 rst=0 during READ beat 2 -> immediately IDLE, all outputs 0, no further valid beats; new request after release served normally.
REQ-033 p0 holds cmd_en continuously (back-to-back reads) with p1 waiting -> with macro, grants alternate p0,p1.
